// File: rtl/sys_reset_ctrl_if.sv
// Reset controller request/response bundle.
// Requests flow in from the core and watchdog; stretched resets flow out.
interface sys_reset_ctrl_if;
  logic       sys_reset_req;
  logic       lockup;
  logic       lockup_rst_en;
  logic       wdog_rst;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       rst_active;
  logic [1:0] rst_cause;

  modport master (
    output sys_reset_req, lockup, lockup_rst_en, wdog_rst,
    input  periph_rst_n, core_rst_n, rst_active, rst_cause
  );

  modport slave (
    input  sys_reset_req, lockup, lockup_rst_en, wdog_rst,
    output periph_rst_n, core_rst_n, rst_active, rst_cause
  );
endinterface

// File: rtl/sys_reset_ctrl.sv
// System reset sequencer: sync-released, stretched peripheral reset
// followed two cycles later by core reset, with last-cause capture.
module sys_reset_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 5
) (
  input logic             clk,
  input logic             rst,
  sys_reset_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ASSERT, HOLD, PERIPH, RUN
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(HOLD_CYCLES);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   ph;
  logic                   periph_q;
  logic                   core_q;
  logic                   active_q;
  logic [1:0]             cause_q;
  logic                   req;
  logic [1:0]             cause_nxt;

  assign bus.periph_rst_n = periph_q;
  assign bus.core_rst_n   = core_q;
  assign bus.rst_active   = active_q;
  assign bus.rst_cause    = cause_q;

  assign req = bus.wdog_rst
             | (bus.lockup & bus.lockup_rst_en)
             | bus.sys_reset_req;

  // Requests may coincide; watchdog wins, then lockup.
  always_comb begin
    cause_nxt = 2'b01;
    if (bus.wdog_rst)
      cause_nxt = 2'b11;
    else if (bus.lockup && bus.lockup_rst_en)
      cause_nxt = 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sync <= '0;
    else
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ASSERT;
      cnt      <= '0;
      ph       <= 1'b0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      active_q <= 1'b1;
      cause_q  <= 2'b00;
    end else begin
      unique case (state)
        ASSERT: begin
          if (sync[SYNC_STAGES-1]) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (cnt != FULL)
            cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= PERIPH;
            periph_q <= 1'b1;
            ph       <= 1'b0;
          end
        end
        PERIPH: begin
          if (ph) begin
            state    <= RUN;
            core_q   <= 1'b1;
            active_q <= 1'b0;
          end else begin
            ph <= 1'b1;
          end
        end
        RUN: begin
          // Internal resets skip the synchronizer; it is already released.
          if (req) begin
            state    <= HOLD;
            cnt      <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            active_q <= 1'b1;
            cause_q  <= cause_nxt;
          end
        end
        default: state <= ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Directed scoreboard bench for sys_reset_ctrl.
// Two instances: default parameters, and SYNC_STAGES=3/HOLD_CYCLES=4.
module tb_sys_reset_ctrl;

  logic clk;
  logic rst;
  logic rst2;

  sys_reset_ctrl_if b1 ();
  sys_reset_ctrl_if b2 ();

  sys_reset_ctrl dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  sys_reset_ctrl #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (4),
    .CNT_W       (3)
  ) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    bit         dut;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  function automatic logic [4:0] obs1();
    return {b1.periph_rst_n, b1.core_rst_n,
            b1.rst_active, b1.rst_cause};
  endfunction

  function automatic logic [4:0] obs2();
    return {b2.periph_rst_n, b2.core_rst_n,
            b2.rst_active, b2.rst_cause};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string tag, bit d, logic [4:0] v);
    exp_t e;
    e.tag = tag;
    e.dut = d;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t       e;
    logic [4:0] o;
    e = sb.pop_front();
    o = e.dut ? obs2() : obs1();
    vectors++;
    assert (o === e.val) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b",
             e.tag, o, e.val);
    end
  endtask

  task automatic step(string tag, bit d, logic [4:0] v);
    push(tag, d, v);
    tick();
    pop_chk();
  endtask

  // Edges after request: low until h, periph high at h, core at h+2.
  task automatic rel(string tag, bit d, int h, logic [1:0] c);
    for (int m = 1; m <= h + 2; m++) begin
      if (m < h)
        step(tag, d, {3'b001, c});
      else if (m < h + 2)
        step(tag, d, {3'b101, c});
      else
        step(tag, d, {3'b110, c});
    end
  endtask

  // Edge e counted from first edge with rst high.
  task automatic pin(string tag, bit d, int s, int h);
    for (int e = 1; e <= s + h + 3; e++) begin
      if (e < s + h + 1)
        step(tag, d, 5'b00100);
      else if (e < s + h + 3)
        step(tag, d, 5'b10100);
      else
        step(tag, d, 5'b11000);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    rst2 = 1'b1;
    b1.sys_reset_req = 1'b0;
    b1.lockup        = 1'b0;
    b1.lockup_rst_en = 1'b0;
    b1.wdog_rst      = 1'b0;
    b2.sys_reset_req = 1'b0;
    b2.lockup        = 1'b0;
    b2.lockup_rst_en = 1'b0;
    b2.wdog_rst      = 1'b0;
    #1;
    rst  = 1'b0;
    rst2 = 1'b0;

    // 1: pin reset, release at edges 19/21
    for (int i = 0; i < 5; i++)
      step("rst_hold", 0, 5'b00100);
    rst = 1'b1;
    pin("pin_rel", 0, 2, 16);

    // 2: soft reset pulse
    b1.sys_reset_req = 1'b1;
    step("soft_req", 0, 5'b00101);
    b1.sys_reset_req = 1'b0;
    rel("soft_rel", 0, 16, 2'b01);

    // 3: coincident requests, then lockup alone
    b1.wdog_rst      = 1'b1;
    b1.lockup        = 1'b1;
    b1.lockup_rst_en = 1'b1;
    b1.sys_reset_req = 1'b1;
    step("prio_req", 0, 5'b00111);
    b1.wdog_rst      = 1'b0;
    b1.lockup        = 1'b0;
    b1.sys_reset_req = 1'b0;
    rel("prio_rel", 0, 16, 2'b11);
    b1.lockup = 1'b1;
    step("lock_req", 0, 5'b00110);
    b1.lockup = 1'b0;
    rel("lock_rel", 0, 16, 2'b10);

    // 4: lockup masked, then enabled and held
    b1.lockup_rst_en = 1'b0;
    b1.lockup        = 1'b1;
    for (int i = 0; i < 5; i++)
      step("lock_dis", 0, 5'b11010);
    b1.lockup_rst_en = 1'b1;
    step("lock_go", 0, 5'b00110);
    rel("lock_held", 0, 16, 2'b10);
    step("lock_loop", 0, 5'b00110);
    b1.lockup        = 1'b0;
    b1.lockup_rst_en = 1'b0;
    rel("lock_end", 0, 16, 2'b10);
    step("lock_idle", 0, 5'b11010);

    // 5: pin reset mid-HOLD after soft reset
    b1.sys_reset_req = 1'b1;
    step("abort_req", 0, 5'b00101);
    b1.sys_reset_req = 1'b0;
    for (int i = 1; i < 8; i++)
      step("abort_hold", 0, 5'b00101);
    rst = 1'b0;
    #2;
    push("async_clr", 0, 5'b00100);
    pop_chk();
    step("abort_low", 0, 5'b00100);
    step("abort_low", 0, 5'b00100);
    rst = 1'b1;
    pin("abort_rel", 0, 2, 16);

    // 6: short config, rst re-pulsed before release completes
    step("p6_low", 1, 5'b00100);
    rst2 = 1'b1;
    step("p6_early", 1, 5'b00100);
    step("p6_early", 1, 5'b00100);
    rst2 = 1'b0;
    #2;
    push("p6_async", 1, 5'b00100);
    pop_chk();
    step("p6_low", 1, 5'b00100);
    rst2 = 1'b1;
    pin("p6_rel", 1, 3, 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
